// File: rtl/mips_muldiv_unit_if.sv
// rtl/mips_muldiv_unit_if.sv - execute-stage bus between core control and the mul/div unit
interface mips_muldiv_unit_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             we_hi;
   logic             we_lo;
   logic [WIDTH-1:0] wdata;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, op, a, b, we_hi, we_lo, wdata,
      input  busy, done, hi, lo
   );

   modport slave (
      input  start, op, a, b, we_hi, we_lo, wdata,
      output busy, done, hi, lo
   );
endinterface

// File: rtl/mips_muldiv_unit.sv
// rtl/mips_muldiv_unit.sv - iterative MULT/MULTU/DIV/DIVU unit owning HI/LO
// Signed ops run on magnitudes; the sign is restored on the final step.
module mips_muldiv_unit #(
   parameter int WIDTH = 32,
   parameter int STEPS = 32
) (
   input  logic                clock,
   input  logic                reset,
   mips_muldiv_unit_if.slave   bus
);
   localparam int CW = $clog2(STEPS);
   localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               is_div_q, is_div_d;
   logic               neg_q_q, neg_q_d;
   logic               neg_r_q, neg_r_d;
   logic               div0_q, div0_d;
   logic [WIDTH-1:0]   opb_q, opb_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   rem_q, rem_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;

   logic               accept;
   logic               a_neg, b_neg;
   logic [WIDTH-1:0]   a_abs, b_abs;
   logic [WIDTH:0]     msum;
   logic [2*WIDTH-1:0] acc_mul, prod_fix;
   logic [WIDTH:0]     shifted, diff;
   logic               qbit;
   logic [WIDTH-1:0]   rem_div, quo, quo_fix, rem_fix;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      is_div_d = is_div_q;
      neg_q_d  = neg_q_q;
      neg_r_d  = neg_r_q;
      div0_d   = div0_q;
      opb_d    = opb_q;
      acc_d    = acc_q;
      rem_d    = rem_q;
      hi_d     = hi_q;
      lo_d     = lo_q;

      accept = bus.start && (state_q != S_RUN);
      a_neg  = ~bus.op[0] & bus.a[WIDTH-1];
      b_neg  = ~bus.op[0] & bus.b[WIDTH-1];
      a_abs  = a_neg ? -bus.a : bus.a;
      b_abs  = b_neg ? -bus.b : bus.b;

      // Shift-add: multiplier sits in the low half and is consumed LSB first
      msum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
      acc_mul = {msum, acc_q[WIDTH-1:1]};

      // Restoring divide: dividend bits leave the low half MSB first, quotient bits enter
      shifted = {rem_q, acc_q[WIDTH-1]};
      diff    = shifted - {1'b0, opb_q};
      qbit    = ~diff[WIDTH];
      rem_div = qbit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
      quo     = {acc_q[WIDTH-2:0], qbit};

      prod_fix = neg_q_q ? -acc_mul : acc_mul;
      quo_fix  = div0_q ? '1 : (neg_q_q ? -quo : quo);
      rem_fix  = neg_r_q ? -rem_div : rem_div;

      case (state_q)
         S_RUN: begin
            cnt_d = cnt_q + 1'b1;
            acc_d = is_div_q ? {{WIDTH{1'b0}}, quo} : acc_mul;
            rem_d = rem_div;
            if (cnt_q == LAST) begin
               state_d = S_DONE;
               cnt_d   = '0;
               if (is_div_q) begin
                  hi_d = rem_fix;
                  lo_d = quo_fix;
               end else begin
                  {hi_d, lo_d} = prod_fix;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            if (accept) begin
               state_d  = S_RUN;
               cnt_d    = '0;
               rem_d    = '0;
               is_div_d = bus.op[1];
               neg_q_d  = a_neg ^ b_neg;
               neg_r_d  = a_neg;
               div0_d   = (bus.b == '0);
               opb_d    = bus.op[1] ? b_abs : a_abs;
               acc_d    = {{WIDTH{1'b0}}, bus.op[1] ? a_abs : b_abs};
            end else begin
               if (bus.we_hi) hi_d = bus.wdata;
               if (bus.we_lo) lo_d = bus.wdata;
            end
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         is_div_q <= 1'b0;
         neg_q_q  <= 1'b0;
         neg_r_q  <= 1'b0;
         div0_q   <= 1'b0;
         opb_q    <= '0;
         acc_q    <= '0;
         rem_q    <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         is_div_q <= is_div_d;
         neg_q_q  <= neg_q_d;
         neg_r_q  <= neg_r_d;
         div0_q   <= div0_d;
         opb_q    <= opb_d;
         acc_q    <= acc_d;
         rem_q    <= rem_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
      end
   end

   assign bus.busy = (state_q == S_RUN);
   assign bus.done = (state_q == S_DONE);
   assign bus.hi   = hi_q;
   assign bus.lo   = lo_q;
endmodule

// File: tb/tb_mips_muldiv_unit.sv
// tb/tb_mips_muldiv_unit.sv - scoreboard bench for mips_muldiv_unit
module tb_mips_muldiv_unit;
   logic clock = 1'b0;
   logic reset = 1'b1;

   mips_muldiv_unit_if #(.WIDTH(32)) bus ();
   mips_muldiv_unit #(.WIDTH(32), .STEPS(32)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          cyc;
      string       name;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int busy_run = 0;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding request
   always @(negedge clock) begin
      if (bus.done === 1'b1) begin
         if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL done_unexpected: got done=1 expected no pulse");
         end else begin
            e = sb.pop_front();
            check({e.name, "_hi"}, {32'h0, bus.hi}, {32'h0, e.hi});
            check({e.name, "_lo"}, {32'h0, bus.lo}, {32'h0, e.lo});
            check({e.name, "_latency"}, 64'(cyc - e.cyc), 64'd33);
            check({e.name, "_busy_cycles"}, 64'(busy_run), 64'd32);
            check({e.name, "_busy_in_done"}, {63'h0, bus.busy}, 64'h0);
         end
         busy_run = 0;
      end else if (bus.busy === 1'b1) begin
         busy_run++;
      end else begin
         busy_run = 0;
      end
   end

   task automatic issue(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                        input bit with_we_hi);
      exp_t x;
      bus.start = 1'b1;
      bus.op    = op;
      bus.a     = a;
      bus.b     = b;
      bus.we_hi = with_we_hi;
      bus.wdata = 32'hDEADBEEF;
      x.hi   = eh;
      x.lo   = el;
      x.cyc  = cyc;
      x.name = name;
      sb.push_back(x);
      @(negedge clock);
      bus.start = 1'b0;
      bus.we_hi = 1'b0;
   endtask

   task automatic wait_done(input bit to_idle);
      int n = 0;
      while (bus.done !== 1'b1 && n < 40) begin
         @(negedge clock);
         n++;
      end
      if (bus.done !== 1'b1) begin
         tests++;
         fails++;
         $display("FAIL wait_done_timeout: got no done expected done within 40 cycles");
      end
      if (to_idle) @(negedge clock);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1);
   end

   initial begin
      bus.start = 1'b0;
      bus.op    = 2'b00;
      bus.a     = '0;
      bus.b     = '0;
      bus.we_hi = 1'b0;
      bus.we_lo = 1'b0;
      bus.wdata = '0;
      repeat (3) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      check("reset_busy", {63'h0, bus.busy}, 64'h0);
      check("reset_done", {63'h0, bus.done}, 64'h0);
      check("reset_hi", {32'h0, bus.hi}, 64'h0);
      check("reset_lo", {32'h0, bus.lo}, 64'h0);

      issue("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
      wait_done(1'b1);
      issue("mult_m1", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0);
      wait_done(1'b1);
      issue("mult_m7x3", 2'b00, 32'hFFFFFFF9, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
      wait_done(1'b1);
      issue("div_m7d2", 2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
      wait_done(1'b1);
      issue("divu_100d7", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
      wait_done(1'b1);
      issue("div_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0);
      wait_done(1'b1);
      issue("divu_by0", 2'b11, 32'h00001234, 32'h0, 32'h00001234, 32'hFFFFFFFF, 1'b0);
      wait_done(1'b1);
      issue("div_neg_by0", 2'b10, 32'hFFFFFFF9, 32'h0, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b0);
      wait_done(1'b1);

      // Stray starts with different operands during RUN must be ignored
      issue("multu_stray", 2'b01, 32'h00010001, 32'h00010001, 32'h00000001, 32'h00020001, 1'b0);
      repeat (3) @(negedge clock);
      bus.start = 1'b1; bus.op = 2'b11; bus.a = 32'd5; bus.b = 32'd0;
      @(negedge clock);
      bus.start = 1'b0;
      repeat (14) @(negedge clock);
      bus.start = 1'b1; bus.op = 2'b00; bus.a = 32'h7; bus.b = 32'h9;
      @(negedge clock);
      bus.start = 1'b0;
      wait_done(1'b0);

      // Start accepted in the DONE cycle; MTLO during its RUN is dropped
      issue("div_7dm2_b2b", 2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0);
      bus.we_lo = 1'b1;
      bus.wdata = 32'h12345678;
      @(negedge clock);
      bus.we_lo = 1'b0;
      check("mtlo_in_run", {32'h0, bus.lo}, {32'h0, 32'h00020001});
      wait_done(1'b1);

      bus.we_hi = 1'b1;
      bus.wdata = 32'hA5A5A5A5;
      @(negedge clock);
      bus.we_hi = 1'b0;
      check("mthi_idle_hi", {32'h0, bus.hi}, {32'h0, 32'hA5A5A5A5});
      check("mthi_idle_lo", {32'h0, bus.lo}, {32'h0, 32'hFFFFFFFD});
      bus.we_hi = 1'b1;
      bus.we_lo = 1'b1;
      bus.wdata = 32'h0F0F0F0F;
      @(negedge clock);
      bus.we_hi = 1'b0;
      bus.we_lo = 1'b0;
      check("mthilo_hi", {32'h0, bus.hi}, {32'h0, 32'h0F0F0F0F});
      check("mthilo_lo", {32'h0, bus.lo}, {32'h0, 32'h0F0F0F0F});

      issue("multu_wehi", 2'b01, 32'd3, 32'd4, 32'h0, 32'd12, 1'b1);
      wait_done(1'b1);

      // Reset mid-operation discards the partial result
      issue("multu_reset", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
      repeat (8) @(negedge clock);
      reset = 1'b1;
      sb.delete();
      @(negedge clock);
      reset = 1'b0;
      check("midreset_busy", {63'h0, bus.busy}, 64'h0);
      check("midreset_done", {63'h0, bus.done}, 64'h0);
      check("midreset_hi", {32'h0, bus.hi}, 64'h0);
      check("midreset_lo", {32'h0, bus.lo}, 64'h0);
      repeat (45) @(negedge clock);

      check("scoreboard_empty", 64'(sb.size()), 64'h0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
